// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit, 5-stage CPU front end.
//   - Conditional-branch opcode constants (BLT/BGT/BEQ)
//   - 2-bit saturating branch counter encodings
//   - PC width
//   - is_branch(): classifies an opcode as a conditional branch
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int unsigned PC_W = 16;

    localparam logic [3:0] OP_BLT = 4'b0100;
    localparam logic [3:0] OP_BGT = 4'b0101;
    localparam logic [3:0] OP_BEQ = 4'b0110;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,   // strongly not-taken
        CTR_WNT = 2'b01,   // weakly not-taken
        CTR_WT  = 2'b10,   // weakly taken
        CTR_ST  = 2'b11    // strongly taken
    } ctr_e;

    function automatic logic is_branch(input logic [3:0] op);
        logic w_hit;
        case (op)
            OP_BLT, OP_BGT, OP_BEQ: w_hit = 1'b1;
            default:                w_hit = 1'b0;
        endcase
        return w_hit;
    endfunction

endpackage

// File: rtl/bp_counter_table.sv
// ----------------------------------------------------------------------------
// bp_counter_table
// ENTRIES x 2-bit saturating counter storage for the branch predictor.
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous active-high reset; all entries load INIT_CTR
//   i_rd_idx     - combinational read index
//   o_rd_ctr     - counter at i_rd_idx (pre-update value, no bypass)
//   i_wr_en      - apply a training update this cycle
//   i_wr_idx     - entry to train
//   i_wr_taken   - actual outcome: 1 increments, 0 decrements (saturating)
// ----------------------------------------------------------------------------
module bp_counter_table
    import cpu_pkg::*;
#(
    parameter int unsigned ENTRIES  = 16,
    parameter logic [1:0]  INIT_CTR = CTR_WNT,
    localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [1:0]       o_rd_ctr,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    logic [1:0] r_ctr [ENTRIES];
    logic [1:0] w_cur;
    logic [1:0] w_next;

    assign o_rd_ctr = r_ctr[i_rd_idx];
    assign w_cur    = r_ctr[i_wr_idx];

    always_comb begin
        w_next = w_cur;
        if (i_wr_taken) begin
            if (w_cur != CTR_ST) begin
                w_next = w_cur + 2'd1;
            end
        end else begin
            if (w_cur != CTR_SNT) begin
                w_next = w_cur - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= INIT_CTR;
            end
        end else if (i_wr_en) begin
            r_ctr[i_wr_idx] <= w_next;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// ----------------------------------------------------------------------------
// branch_predictor
// Fetch-side bimodal predictor paired with the execute-stage comparator.
// Predicts BLT/BGT/BEQ using a table of 2-bit saturating counters indexed by
// the low PC bits (untagged), trains on resolve, and raises a registered
// one-cycle flush with a redirect PC on a mispredict.
//
// Optional feature macro: BP_STATS_EN
//   defined   -> stat_branches / stat_mispredicts saturating counters present
//   undefined -> those ports and their logic are absent
//
// Ports:
//   clk, rst          - clock (rising edge), async active-high reset
//   f_valid, f_pc,
//   f_opcode, f_target- fetch slot
//   pred_taken        - combinational prediction for the fetch slot
//   pred_pc           - combinational next fetch PC
//   r_valid, r_pc,
//   r_opcode, r_taken,
//   r_pred_taken,
//   r_target          - resolving branch from execute
//   flush             - registered squash pulse
//   redirect_pc       - registered correct PC, valid while flush=1
//   stat_branches     - (BP_STATS_EN) count of trained resolves
//   stat_mispredicts  - (BP_STATS_EN) count of mispredicts
// ----------------------------------------------------------------------------
module branch_predictor
    import cpu_pkg::*;
#(
    parameter int unsigned ENTRIES  = 16,
    parameter logic [1:0]  INIT_CTR = CTR_WNT,
    localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            f_valid,
    input  logic [PC_W-1:0] f_pc,
    input  logic [3:0]      f_opcode,
    input  logic [PC_W-1:0] f_target,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_pc,
    input  logic            r_valid,
    input  logic [PC_W-1:0] r_pc,
    input  logic [3:0]      r_opcode,
    input  logic            r_taken,
    input  logic            r_pred_taken,
    input  logic [PC_W-1:0] r_target,
    output logic            flush,
    output logic [PC_W-1:0] redirect_pc
`ifdef BP_STATS_EN
    ,
    output logic [15:0]     stat_branches,
    output logic [15:0]     stat_mispredicts
`endif
);

    logic [1:0]      w_rd_ctr;
    logic            w_pred_taken;
    logic            w_upd;
    logic            w_mispredict;
    logic            r_flush;
    logic [PC_W-1:0] r_redirect_pc;

    bp_counter_table #(
        .ENTRIES  (ENTRIES),
        .INIT_CTR (INIT_CTR)
    ) u_table (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (f_pc[IDX_W-1:0]),
        .o_rd_ctr   (w_rd_ctr),
        .i_wr_en    (w_upd),
        .i_wr_idx   (r_pc[IDX_W-1:0]),
        .i_wr_taken (r_taken)
    );

    // Predict path: zero latency, reads the pre-update counter.
    assign w_pred_taken = f_valid & is_branch(f_opcode) & w_rd_ctr[1];
    assign pred_taken   = w_pred_taken;
    assign pred_pc      = w_pred_taken ? f_target : f_pc + 16'd1;

    // A resolve arriving while flush is high is wrong-path and is dropped,
    // which also guarantees one flush pulse per real mispredict.
    assign w_upd        = r_valid & is_branch(r_opcode) & ~r_flush;
    assign w_mispredict = w_upd & (r_taken != r_pred_taken);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush       <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_flush <= w_mispredict;
            if (w_mispredict) begin
                r_redirect_pc <= r_taken ? r_target : r_pc + 16'd1;
            end
        end
    end

    assign flush       = r_flush;
    assign redirect_pc = r_redirect_pc;

`ifdef BP_STATS_EN
    logic [15:0] r_stat_branches;
    logic [15:0] r_stat_mispredicts;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (w_upd && (r_stat_branches != '1)) begin
                r_stat_branches <= r_stat_branches + 16'd1;
            end
            if (w_mispredict && (r_stat_mispredicts != '1)) begin
                r_stat_mispredicts <= r_stat_mispredicts + 16'd1;
            end
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule
